reuleaux_ctrl: RTL and testbench

- Top-level sequencer for Reuleaux triangle drawing.
- Takes a centre and diameter, computes the three triangle vertices in fixed point, and runs one shared arc/circle engine three times, once per vertex, with radius = diameter.
- Filters the engine's pixel stream so only the Reuleaux boundary segment of each circle reaches the VGA adapter.
- Sits between the task top and the arc engine; drives vga_* directly.

---
 rtl/reuleaux_ctrl.sv | 164 ++++++++++++++++
 tb/tb_reuleaux_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/reuleaux_ctrl.sv
// Reuleaux triangle sequencer: derives three vertices from centre/diameter, runs the
// shared arc engine once per vertex and passes only the boundary arc of each circle to VGA.
module reuleaux_ctrl #(
    parameter int SCR_W = 160,
    parameter int SCR_H = 120,
    parameter int K6    = 37,
    parameter int K3    = 74
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] colour,
    input  logic [7:0] centre_x,
    input  logic [7:0] centre_y,
    input  logic [7:0] diameter,
    output logic       finished,
    output logic       error,
    output logic       arc_start,
    output logic [7:0] arc_centre_x,
    output logic [7:0] arc_centre_y,
    output logic [7:0] arc_radius,
    input  logic       arc_finished,
    input  logic [7:0] arc_x,
    input  logic [6:0] arc_y,
    input  logic       arc_plot,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot
);

    typedef enum logic [3:0] {
        S_IDLE, S_CALC, S_RUN0, S_REL0, S_RUN1, S_REL1, S_RUN2, S_REL2, S_DONE
    } state_t;

    localparam logic signed [9:0] X_MAX = 10'(SCR_W - 1);
    localparam logic signed [9:0] Y_MAX = 10'(SCR_H - 1);

    state_t     state_reg, state_next;
    logic [2:0] colour_reg;
    logic [7:0] cx_reg, cy_reg, d_reg;
    logic [7:0] vx_reg [3];
    logic [6:0] vy_reg [3];
    logic       finished_reg, error_reg;

    logic [8:0]        h6_u, h3_u;
    logic signed [9:0] half_s, h6_s, h3_s, cx_s, cy_s;
    logic signed [9:0] vx_calc [3];
    logic signed [9:0] vy_calc [3];
    logic [2:0]        vert_bad;
    logic              calc_bad;
    logic [1:0]        sel;
    logic              keep;

    assign h6_u   = 9'((16'(d_reg) * 16'(K6)) >> 7);
    assign h3_u   = 9'((16'(d_reg) * 16'(K3)) >> 7);
    assign half_s = $signed({2'b00, d_reg >> 1});
    assign h6_s   = $signed({1'b0, h6_u});
    assign h3_s   = $signed({1'b0, h3_u});
    assign cx_s   = $signed({2'b00, cx_reg});
    assign cy_s   = $signed({2'b00, cy_reg});

    assign vx_calc[0] = cx_s;
    assign vy_calc[0] = cy_s - h3_s;
    assign vx_calc[1] = cx_s - half_s;
    assign vy_calc[1] = cy_s + h6_s;
    assign vx_calc[2] = cx_s + half_s;
    assign vy_calc[2] = cy_s + h6_s;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_vertex
            assign vert_bad[gi] = (vx_calc[gi] < 10'sd0) || (vx_calc[gi] > X_MAX) ||
                                  (vy_calc[gi] < 10'sd0) || (vy_calc[gi] > Y_MAX);

            // Vertices only update on a clean CALC so the engine params stay frozen otherwise
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    vx_reg[gi] <= '0;
                    vy_reg[gi] <= '0;
                end else if (state_reg == S_CALC && !calc_bad) begin
                    vx_reg[gi] <= vx_calc[gi][7:0];
                    vy_reg[gi] <= vy_calc[gi][6:0];
                end
            end
        end
    endgenerate

    assign calc_bad = |vert_bad;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            colour_reg   <= '0;
            cx_reg       <= '0;
            cy_reg       <= '0;
            d_reg        <= '0;
            finished_reg <= 1'b0;
            error_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            finished_reg <= (state_next == S_DONE);
            if (state_reg == S_IDLE && start) begin
                colour_reg <= colour;
                cx_reg     <= centre_x;
                cy_reg     <= centre_y;
                d_reg      <= diameter;
            end
            if (state_reg == S_CALC && calc_bad)
                error_reg <= 1'b1;
            else if (state_reg == S_DONE && !start)
                error_reg <= 1'b0;
        end
    end

    always_comb begin
        state_next = state_reg;
        arc_start  = 1'b0;
        sel        = 2'd0;
        keep       = 1'b0;
        case (state_reg)
            S_IDLE: if (start) state_next = S_CALC;
            S_CALC: state_next = calc_bad ? S_DONE : S_RUN0;
            S_RUN0: begin
                arc_start = 1'b1;
                keep      = (arc_y >= vy_reg[1]);
                if (arc_finished) state_next = S_REL0;
            end
            S_REL0: if (!arc_finished) state_next = S_RUN1;
            S_RUN1: begin
                arc_start = 1'b1;
                sel       = 2'd1;
                keep      = (arc_x >= cx_reg) && (arc_y <= vy_reg[1]);
                if (arc_finished) state_next = S_REL1;
            end
            S_REL1: begin
                sel = 2'd1;
                if (!arc_finished) state_next = S_RUN2;
            end
            S_RUN2: begin
                arc_start = 1'b1;
                sel       = 2'd2;
                keep      = (arc_x <= cx_reg) && (arc_y <= vy_reg[1]);
                if (arc_finished) state_next = S_REL2;
            end
            S_REL2: begin
                sel = 2'd2;
                if (!arc_finished) state_next = S_DONE;
            end
            S_DONE: if (!start) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign finished     = finished_reg;
    assign error        = error_reg;
    assign arc_centre_x = vx_reg[sel];
    assign arc_centre_y = {1'b0, vy_reg[sel]};
    assign arc_radius   = d_reg;
    assign vga_x        = arc_x;
    assign vga_y        = arc_y;
    assign vga_colour   = colour_reg;
    assign vga_plot     = arc_plot & keep;

endmodule

// File: tb/tb_reuleaux_ctrl.sv
// Directed bench for reuleaux_ctrl with a hand-driven stub arc engine.
module tb_reuleaux_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, start, arc_finished, arc_plot;
    logic [2:0] colour;
    logic [7:0] centre_x, centre_y, diameter, arc_x;
    logic [6:0] arc_y;
    logic       finished, error, arc_start, vga_plot;
    logic [7:0] arc_centre_x, arc_centre_y, arc_radius, vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int         run;
        logic [7:0] x;
        logic [6:0] y;
        logic       exp_plot;
    } fvec_t;
    fvec_t fv [12];

    reuleaux_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .colour(colour),
        .centre_x(centre_x), .centre_y(centre_y), .diameter(diameter),
        .finished(finished), .error(error), .arc_start(arc_start),
        .arc_centre_x(arc_centre_x), .arc_centre_y(arc_centre_y), .arc_radius(arc_radius),
        .arc_finished(arc_finished), .arc_x(arc_x), .arc_y(arc_y), .arc_plot(arc_plot),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end else
            $display("ok   %s = %0d", nm, act);
    endtask

    task automatic wait_arc_start(input string nm);
        int n = 0;
        while (!arc_start && n < 20) begin
            step();
            n++;
        end
        chk({nm, "_arc_start_seen"}, 16'(arc_start), 16'd1);
    endtask

    // One engine run: check params, optional filter vectors, then finish/release handshake
    task automatic run_engine(input int k, input int hold, input bit do_filter,
                              input logic [7:0] ex, input logic [7:0] ey,
                              input logic [7:0] er, input logic [2:0] ecol);
        string tag;
        tag = $sformatf("run%0d", k);
        wait_arc_start(tag);
        chk({tag, "_cx"}, 16'(arc_centre_x), 16'(ex));
        chk({tag, "_cy"}, 16'(arc_centre_y), 16'(ey));
        chk({tag, "_r"},  16'(arc_radius),   16'(er));
        if (do_filter) begin
            for (int i = 0; i < 12; i++) begin
                if (fv[i].run == k) begin
                    arc_x = fv[i].x; arc_y = fv[i].y; arc_plot = 1'b1;
                    #1;
                    chk($sformatf("%s_plot_%0d_%0d", tag, fv[i].x, fv[i].y),
                        16'(vga_plot), 16'(fv[i].exp_plot));
                    chk({tag, "_vga_x"}, 16'(vga_x), 16'(fv[i].x));
                    chk({tag, "_vga_y"}, 16'(vga_y), 16'(fv[i].y));
                    chk({tag, "_colour"}, 16'(vga_colour), 16'(ecol));
                end
            end
            arc_plot = 1'b0;
        end
        step();
        chk({tag, "_still_start"}, 16'(arc_start), 16'd1);
        chk({tag, "_stable_cx"}, 16'(arc_centre_x), 16'(ex));
        arc_finished = 1'b1;
        for (int h = 0; h < hold; h++) begin
            step();
            arc_plot = 1'b1; arc_x = ex; arc_y = 7'(ey);
            #1;
            chk({tag, "_rel_start_low"}, 16'(arc_start), 16'd0);
            chk({tag, "_rel_no_plot"}, 16'(vga_plot), 16'd0);
            chk({tag, "_rel_held_cy"}, 16'(arc_centre_y), 16'(ey));
            arc_plot = 1'b0;
        end
        arc_finished = 1'b0;
    endtask

    task automatic begin_draw(input logic [7:0] cx, input logic [7:0] cy,
                              input logic [7:0] d, input logic [2:0] col);
        centre_x = cx; centre_y = cy; diameter = d; colour = col;
        start = 1'b1;
    endtask

    initial begin
        fv[0]  = '{0,  8'd80, 7'd120, 1'b1};
        fv[1]  = '{0,  8'd80, 7'd83,  1'b1};
        fv[2]  = '{0,  8'd80, 7'd82,  1'b0};
        fv[3]  = '{0,  8'd60, 7'd90,  1'b1};
        fv[4]  = '{1, 8'd100, 7'd40,  1'b1};
        fv[5]  = '{1,  8'd60, 7'd40,  1'b0};
        fv[6]  = '{1,  8'd80, 7'd83,  1'b1};
        fv[7]  = '{1, 8'd100, 7'd84,  1'b0};
        fv[8]  = '{2,  8'd60, 7'd40,  1'b1};
        fv[9]  = '{2, 8'd100, 7'd90,  1'b0};
        fv[10] = '{2,  8'd80, 7'd83,  1'b1};
        fv[11] = '{2,  8'd81, 7'd40,  1'b0};

        rst_n = 1'b0; start = 1'b0; arc_finished = 1'b0; arc_plot = 1'b0;
        colour = '0; centre_x = '0; centre_y = '0; diameter = '0; arc_x = '0; arc_y = '0;
        step(); step();
        arc_plot = 1'b1;
        #1;
        chk("reset_finished", 16'(finished), 16'd0);
        chk("reset_error", 16'(error), 16'd0);
        chk("reset_arc_start", 16'(arc_start), 16'd0);
        chk("reset_vga_plot", 16'(vga_plot), 16'd0);
        chk("reset_radius", 16'(arc_radius), 16'd0);
        arc_plot = 1'b0;
        rst_n = 1'b1;
        step();

        // Nominal draw, engine holds finished for 5 cycles
        begin_draw(8'd80, 8'd60, 8'd80, 3'd5);
        step();
        chk("latency_calc_no_start", 16'(arc_start), 16'd0);
        step();
        chk("latency_run0_start", 16'(arc_start), 16'd1);
        run_engine(0, 5, 1'b1, 8'd80,  8'd14, 8'd80, 3'd5);
        run_engine(1, 5, 1'b1, 8'd40,  8'd83, 8'd80, 3'd5);
        run_engine(2, 5, 1'b1, 8'd120, 8'd83, 8'd80, 3'd5);
        step();
        chk("nom_finished", 16'(finished), 16'd1);
        chk("nom_error", 16'(error), 16'd0);
        step(); step();
        chk("hold_start_stays_done", 16'(finished), 16'd1);
        chk("done_no_arc_start", 16'(arc_start), 16'd0);
        start = 1'b0;
        step();
        chk("drop_start_finished_clear", 16'(finished), 16'd0);

        // Re-trigger with fresh inputs: half=20 h6=11 h3=23
        begin_draw(8'd60, 8'd50, 8'd40, 3'd2);
        run_engine(0, 1, 1'b0, 8'd60, 8'd27, 8'd40, 3'd2);
        run_engine(1, 1, 1'b0, 8'd40, 8'd61, 8'd40, 3'd2);
        run_engine(2, 1, 1'b0, 8'd80, 8'd61, 8'd40, 3'd2);
        start = 1'b0;
        step();
        chk("retrig_finished", 16'(finished), 16'd1);
        step();
        chk("retrig_idle", 16'(finished), 16'd0);

        // Off-screen: V1 x = -20
        begin_draw(8'd80, 8'd60, 8'd200, 3'd7);
        arc_plot = 1'b1; arc_x = 8'd80; arc_y = 7'd100;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("off_no_arc_start", 16'(arc_start), 16'd0);
            chk("off_no_plot", 16'(vga_plot), 16'd0);
        end
        chk("off_finished", 16'(finished), 16'd1);
        chk("off_error", 16'(error), 16'd1);
        arc_plot = 1'b0;
        start = 1'b0;
        step();
        chk("off_clear_finished", 16'(finished), 16'd0);
        chk("off_clear_error", 16'(error), 16'd0);

        // Reset in the middle of RUN1, then a full redraw from V0
        begin_draw(8'd80, 8'd60, 8'd80, 3'd3);
        run_engine(0, 1, 1'b0, 8'd80, 8'd14, 8'd80, 3'd3);
        wait_arc_start("pre_reset_run1");
        chk("pre_reset_run1_cx", 16'(arc_centre_x), 16'd40);
        rst_n = 1'b0; start = 1'b0;
        step();
        rst_n = 1'b1;
        arc_plot = 1'b1; arc_x = 8'd100; arc_y = 7'd40;
        #1;
        chk("mid_reset_arc_start", 16'(arc_start), 16'd0);
        chk("mid_reset_finished", 16'(finished), 16'd0);
        chk("mid_reset_vga_plot", 16'(vga_plot), 16'd0);
        chk("mid_reset_radius", 16'(arc_radius), 16'd0);
        arc_plot = 1'b0;
        begin_draw(8'd80, 8'd60, 8'd80, 3'd3);
        run_engine(0, 2, 1'b0, 8'd80,  8'd14, 8'd80, 3'd3);
        run_engine(1, 2, 1'b0, 8'd40,  8'd83, 8'd80, 3'd3);
        run_engine(2, 2, 1'b0, 8'd120, 8'd83, 8'd80, 3'd3);
        step();
        chk("redraw_finished", 16'(finished), 16'd1);
        chk("redraw_error", 16'(error), 16'd0);
        start = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
